regfile_read_pipe: RTL and testbench

- Small register file with one write port and a 2-stage pipelined read path.
- The read path uses a valid/ready handshake with backpressure.
- It produces the registered read data that downstream concurrent-property checkers consume, e.g. `$past(regs[index])`-style comparisons.
- It embeds its own concurrent assertions and covers, clocked on posedge `clk` with `disable iff (!rst_n)`.

---
 rtl/regpipe_pkg.sv | 20 ++
 rtl/regfile_read_pipe_if.sv | 34 +++
 rtl/regpipe_slice.sv | 33 +++
 rtl/regfile_read_pipe.sv | 115 +++++++++++
 tb/tb_regfile_read_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/regpipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regpipe_pkg : shared types and constants for the register-file read pipe
// Rev 1.0
// ---------------------------------------------------------------------------
package regpipe_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_BITS = 3;

  localparam logic [DATA_W-1:0] RESET_DATA = '0;

  // One pipeline stage payload: the address read and the value it held
  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_W-1:0]    data;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/regfile_read_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_read_pipe_if : write port, read request and read result channels
// Rev 1.0
// ---------------------------------------------------------------------------
interface regfile_read_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        reads_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr, out_ready,
    input  rd_ready, out_valid, out_data, out_addr, reads_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr, out_ready,
    output rd_ready, out_valid, out_data, out_addr, reads_done
  );

endinterface
`default_nettype wire

// File: rtl/regpipe_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regpipe_slice : one valid/ready register slice, loads whenever it can pass on
// Rev 1.0
// ---------------------------------------------------------------------------
module regpipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Empty or being drained this edge: safe to take a new entry
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_read_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_read_pipe : register file with one write port and a 2-stage read pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_read_pipe
  import regpipe_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_read_pipe_if.slave  bus
);

  // The stage payload type is fixed in the package, so the geometry must match it
  generate
    if (WIDTH != DATA_W || ADDR_W != ADDR_BITS || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
      $error("regfile_read_pipe: unsupported WIDTH/DEPTH/ADDR_W combination");
    end
  endgenerate

  logic [WIDTH-1:0] regs [DEPTH];
  stage_t           s1_in;
  stage_t           s1_q;
  stage_t           s2_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic [7:0]       done_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= WIDTH'(RESET_DATA);
      end
    end else if (bus.wr_en) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // regs updates non-blocking, so a same-edge write is invisible to this capture
  always_comb begin
    s1_in      = '0;
    s1_in.addr = bus.rd_addr;
    s1_in.data = regs[bus.rd_addr];
  end

  regpipe_slice #(
    .W ($bits(stage_t))
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.rd_req),
    .in_ready  (s1_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  regpipe_slice #(
    .W ($bits(stage_t))
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s1_q),
    .out_valid (s2_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 8'd0;
    end else if (s2_valid && bus.out_ready) begin
      done_cnt <= done_cnt + 8'd1;
    end
  end

  assign bus.rd_ready   = s1_ready;
  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_q.data;
  assign bus.out_addr   = s2_q.addr;
  assign bus.reads_done = done_cnt;

  generate
    if (ASSERT_EN) begin : g_assert
      p_hold: assert property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid && !bus.out_ready |=>
          bus.out_valid && $stable(bus.out_data) && $stable(bus.out_addr));

      p_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !bus.rd_ready |-> bus.out_valid && !bus.out_ready);

      // Antecedent also requires reset to have been high on both earlier edges
      p_lat: assert property (@(posedge clk) disable iff (!rst_n)
        $past(rst_n, 2) && $past(rst_n, 1) &&
        $past(bus.rd_req && bus.rd_ready, 2) && $past(bus.out_ready, 1) |->
          bus.out_valid && bus.out_addr == $past(bus.rd_addr, 2));

      c_aa: cover property (@(posedge clk) disable iff (!rst_n)
        bus.out_valid && bus.out_ready && bus.out_data == WIDTH'(8'hAA));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_read_pipe : directed and random stimulus against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_read_pipe;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  regfile_read_pipe_if #(.WIDTH(8), .ADDR_W(3)) bus ();

  regfile_read_pipe #(
    .WIDTH     (8),
    .DEPTH     (8),
    .ADDR_W    (3),
    .ASSERT_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  int         n_acc;
  logic [7:0] regs_m [8];
  ent_t       q [$];
  logic [7:0] exp_done;
  logic       stall_prev;
  logic [7:0] prev_data;
  logic [2:0] prev_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;
    q.delete();
    exp_done   = 8'd0;
    stall_prev = 1'b0;
  endtask

  // Check the cycle, advance the model to what the coming edge must do, take the edge
  task automatic step();
    ent_t e;
    logic acc;
    logic hs;
    @(negedge clk);
    check("rd_ready", bus.rd_ready, (q.size() < 2) || bus.out_ready);
    check("reads_done", bus.reads_done, exp_done);
    check("valid_when_empty", bus.out_valid && (q.size() == 0), 0);
    if (stall_prev) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, prev_data);
      check("hold_addr", bus.out_addr, prev_addr);
    end
    acc = bus.rd_req && bus.rd_ready;
    hs  = bus.out_valid && bus.out_ready;
    if (hs && q.size() != 0) begin
      e = q.pop_front();
      check("out_data", bus.out_data, e.data);
      check("out_addr", bus.out_addr, e.addr);
      exp_done = exp_done + 8'd1;
    end
    if (acc) begin
      e.addr = bus.rd_addr;
      e.data = regs_m[bus.rd_addr];
      q.push_back(e);
      n_acc++;
    end
    if (bus.wr_en) regs_m[bus.wr_addr] = bus.wr_data;
    stall_prev = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_addr  = bus.out_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.rd_req    = 1'b0;
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) step();
    step();
    check("drained", bus.out_valid, 0);
  endtask

  initial begin
    logic [7:0] base;
    n_vec = 0;
    n_err = 0;
    n_acc = 0;
    model_clear();
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rd_ready", bus.rd_ready, 1);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_reads_done", bus.reads_done, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read with explicit two-edge latency
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'h5A;
    step();
    bus.wr_en = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 3'd3; bus.out_ready = 1'b1;
    step();
    check("lat_not_yet", bus.out_valid, 0);
    bus.rd_req = 1'b0;
    step();
    check("lat_valid", bus.out_valid, 1);
    check("lat_data", bus.out_data, 8'h5A);
    check("lat_addr", bus.out_addr, 3);
    step();
    check("lat_done", bus.reads_done, 1);

    // Read-before-write on a shared edge, then the new value
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'h11;
    step();
    bus.wr_data = 8'hAA; bus.rd_req = 1'b1; bus.rd_addr = 3'd2;
    step();
    bus.wr_en = 1'b0;
    step();
    check("rbw_old", bus.out_data, 8'h11);
    bus.rd_req = 1'b0;
    drain();
    bus.rd_req = 1'b1;
    step();
    drain();

    // Back-to-back reads of every address
    base = bus.reads_done;
    for (int a = 0; a < 8; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = 8'($urandom);
      step();
    end
    bus.wr_en = 1'b0; bus.out_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 3'(a);
      step();
    end
    drain();
    check("b2b_count", 8'(bus.reads_done - base), 8);

    // Backpressure: only two reads fit
    n_acc = 0;
    bus.out_ready = 1'b0; bus.rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.rd_addr = 3'($urandom);
      step();
    end
    check("stall_accepts", n_acc, 2);
    check("stall_rd_ready", bus.rd_ready, 0);
    bus.rd_req = 1'b0;
    drain();

    // Reset with two reads in flight
    bus.out_ready = 1'b0; bus.rd_req = 1'b1;
    step();
    step();
    bus.rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ready", bus.rd_ready, 1);
    check("mid_rst_done", bus.reads_done, 0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 3'(a);
      step();
    end
    drain();

    // reads_done wrap over 256 handshakes
    base = bus.reads_done;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.rd_req = 1'b1; bus.rd_addr = 3'($urandom);
      step();
    end
    drain();
    check("wrap", bus.reads_done, base);

    // Random mix of writes, reads and backpressure
    for (int i = 0; i < 400; i++) begin
      bus.wr_en     = 1'($urandom);
      bus.wr_addr   = 3'($urandom);
      bus.wr_data   = 8'($urandom);
      bus.rd_req    = 1'($urandom);
      bus.rd_addr   = 3'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
